// File: rtl/hybrid_noc_router_input.sv
// Receive side of a hybrid TDM/best-effort router link: registers TDM flits for broadcast and
// buffers BE flits, steering source-routed packets to one output with wormhole locking.
module hybrid_noc_router_input #(
  parameter int FLIT_WIDTH    = 32,
  parameter int PORTS         = 5,
  parameter int BUFFER_DEPTH  = 4,
  parameter int ROUTE_FIELD_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_last,
  input  logic                  in_tdm_valid,
  input  logic                  in_be_valid,
  output logic                  in_be_ready,
  output logic [FLIT_WIDTH-1:0] tdm_out_flit,
  output logic                  tdm_out_valid,
  output logic                  tdm_out_last,
  output logic [FLIT_WIDTH-1:0] be_out_flit,
  output logic                  be_out_last,
  output logic [PORTS-1:0]      be_out_valid,
  input  logic [PORTS-1:0]      be_out_ready,
  output logic                  be_drop
);

  localparam int ROUTE_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int PTR_W   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W   = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUFFER_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // ---------------- TDM path ----------------
  logic [FLIT_WIDTH-1:0] tdm_flit_q, tdm_flit_d;
  logic                  tdm_valid_q, tdm_valid_d;
  logic                  tdm_last_q, tdm_last_d;

  always_comb begin
    tdm_flit_d  = in_flit;
    tdm_valid_d = in_tdm_valid;
    tdm_last_d  = in_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tdm_flit_q  <= '0;
      tdm_valid_q <= 1'b0;
      tdm_last_q  <= 1'b0;
    end else begin
      tdm_flit_q  <= tdm_flit_d;
      tdm_valid_q <= tdm_valid_d;
      tdm_last_q  <= tdm_last_d;
    end
  end

  assign tdm_out_flit  = tdm_flit_q;
  assign tdm_out_valid = tdm_valid_q;
  assign tdm_out_last  = tdm_last_q;

  // ---------------- BE FIFO ----------------
  logic [FLIT_WIDTH:0] mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ready_q, ready_d;
  logic                push, pop;
  logic                head_valid;
  logic [FLIT_WIDTH:0] head_flit;

  // A colliding TDM flit owns the shared flit bus, so the BE beat is dropped on the floor.
  assign push       = in_be_valid & ready_q & ~in_tdm_valid;
  assign head_valid = (count_q != '0);
  assign head_flit  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_flit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign in_be_ready = ready_q;

  // ---------------- Route decode ----------------
  logic [ROUTE_W-1:0]       route_port;
  logic [31:0]              route_port_ext;
  logic                     route_legal;
  logic [ROUTE_FIELD_W-1:0] route_field_shifted;
  logic [FLIT_WIDTH-1:0]    hdr_flit;

  assign route_port          = head_flit[ROUTE_W-1:0];
  assign route_port_ext      = 32'(route_port);
  assign route_legal         = (route_port_ext < 32'(PORTS));
  assign route_field_shifted = head_flit[ROUTE_FIELD_W-1:0] >> ROUTE_W;

  generate
    if (ROUTE_FIELD_W < FLIT_WIDTH) begin : g_hdr_upper
      assign hdr_flit = {head_flit[FLIT_WIDTH-1:ROUTE_FIELD_W], route_field_shifted};
    end else begin : g_hdr_full
      assign hdr_flit = route_field_shifted;
    end
  endgenerate

  // ---------------- Wormhole FSM ----------------
  logic [1:0]         state_q, state_d;
  logic [ROUTE_W-1:0] sel_q, sel_d;
  logic [ROUTE_W-1:0] out_port;
  logic               out_en;
  logic               hdr_mode;
  logic               drop;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pop      = 1'b0;
    drop     = 1'b0;
    out_port = sel_q;
    out_en   = 1'b0;
    hdr_mode = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_valid) begin
          if (route_legal) begin
            out_en   = 1'b1;
            out_port = route_port;
            hdr_mode = 1'b1;
            if (be_out_ready[route_port]) begin
              pop = 1'b1;
              if (!head_flit[FLIT_WIDTH]) begin
                state_d = ST_FWD;
                sel_d   = route_port;
              end
            end
          end else begin
            pop  = 1'b1;
            drop = 1'b1;
            if (!head_flit[FLIT_WIDTH]) state_d = ST_DROP;
          end
        end
      end
      ST_FWD: begin
        out_en = head_valid;
        if (head_valid && be_out_ready[sel_q]) begin
          pop = 1'b1;
          if (head_flit[FLIT_WIDTH]) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (head_valid) begin
          pop = 1'b1;
          if (head_flit[FLIT_WIDTH]) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_valid
      assign be_out_valid[gi] = out_en & (out_port == ROUTE_W'(gi));
    end
  endgenerate

  assign be_out_flit = hdr_mode ? hdr_flit : head_flit[FLIT_WIDTH-1:0];
  assign be_out_last = head_flit[FLIT_WIDTH];
  assign be_drop     = drop;

endmodule

// File: tb/tb_hybrid_noc_router_input.sv
// Scoreboard bench for hybrid_noc_router_input: directed stimulus pushes expectations,
// an independent negedge monitor pops and compares on every TDM beat, BE transfer and drop.
module tb_hybrid_noc_router_input;
  localparam int FW = 32;
  localparam int P  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] in_flit = '0;
  logic          in_last = 1'b0;
  logic          in_tdm_valid = 1'b0;
  logic          in_be_valid = 1'b0;
  logic          in_be_ready;
  logic [FW-1:0] tdm_out_flit;
  logic          tdm_out_valid;
  logic          tdm_out_last;
  logic [FW-1:0] be_out_flit;
  logic          be_out_last;
  logic [P-1:0]  be_out_valid;
  logic [P-1:0]  be_out_ready = '1;
  logic          be_drop;

  hybrid_noc_router_input #(
    .FLIT_WIDTH(FW), .PORTS(P), .BUFFER_DEPTH(4), .ROUTE_FIELD_W(16)
  ) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last),
    .in_tdm_valid(in_tdm_valid), .in_be_valid(in_be_valid), .in_be_ready(in_be_ready),
    .tdm_out_flit(tdm_out_flit), .tdm_out_valid(tdm_out_valid), .tdm_out_last(tdm_out_last),
    .be_out_flit(be_out_flit), .be_out_last(be_out_last), .be_out_valid(be_out_valid),
    .be_out_ready(be_out_ready), .be_drop(be_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    port;
    logic [FW-1:0] flit;
    logic          last;
  } be_exp_t;

  be_exp_t     be_q[$];
  logic [FW:0] tdm_q[$];
  int          drop_pending = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Monitor: decoupled from stimulus, compares against queued expectations.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (tdm_out_valid) begin
        if (tdm_q.size() == 0) flag("tdm_unexpected");
        else begin
          logic [FW:0] t;
          t = tdm_q.pop_front();
          check("tdm_flit", tdm_out_flit, t[FW-1:0]);
          check("tdm_last", tdm_out_last, t[FW]);
        end
      end
      if (be_out_valid != '0) check("be_onehot", $onehot(be_out_valid), 1);
      for (int p = 0; p < P; p++) begin
        if (be_out_valid[p] && be_out_ready[p]) begin
          if (be_q.size() == 0) flag("be_unexpected");
          else begin
            be_exp_t e;
            e = be_q.pop_front();
            check("be_port", p, e.port);
            check("be_flit", be_out_flit, e.flit);
            check("be_last", be_out_last, e.last);
          end
        end
      end
      if (be_drop) begin
        if (drop_pending == 0) flag("be_drop_unexpected");
        else begin
          drop_pending--;
          $display("ok   be_drop pulse");
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_be(input logic [FW-1:0] f, input logic l);
    int w;
    in_flit     = f;
    in_last     = l;
    in_be_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_be_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) flag("send_be_timeout");
    @(posedge clk);
    #1;
    in_be_valid = 1'b0;
    in_last     = 1'b0;
  endtask

  task automatic expect_be(input logic [2:0] port, input logic [FW-1:0] f, input logic l);
    be_exp_t e;
    e.port = port;
    e.flit = f;
    e.last = l;
    be_q.push_back(e);
  endtask

  initial begin
    int w;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tdm_valid", tdm_out_valid, 0);
    check("rst_tdm_flit", tdm_out_flit, 0);
    check("rst_tdm_last", tdm_out_last, 0);
    check("rst_be_valid", be_out_valid, 0);
    check("rst_be_drop", be_drop, 0);
    check("rst_be_ready", in_be_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // TDM single beat, latency 1
    cycles(1);
    in_tdm_valid = 1'b1; in_flit = 32'hA5A5_0001; in_last = 1'b1;
    tdm_q.push_back({1'b1, 32'hA5A5_0001});
    cycles(1);
    in_tdm_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("tdm_lat1_valid", tdm_out_valid, 1);
    check("tdm_lat1_be_valid", be_out_valid, 0);
    cycles(1);

    // 3-flit packet to port 2
    expect_be(3'd2, 32'hDEAD_0002, 1'b0);
    expect_be(3'd2, 32'h1234_5678, 1'b0);
    expect_be(3'd2, 32'h9ABC_DEF0, 1'b1);
    send_be(32'hDEAD_0012, 1'b0);
    send_be(32'h1234_5678, 1'b0);
    send_be(32'h9ABC_DEF0, 1'b1);
    cycles(4);

    // Backpressure on port 1, other ports ready
    be_out_ready = 5'b11101;
    expect_be(3'd1, 32'hCAFE_0008, 1'b0);
    for (int i = 1; i <= 5; i++) expect_be(3'd1, 32'hB0D0_0000 + 32'(i), i == 5);
    fork
      begin
        send_be(32'hCAFE_0041, 1'b0);
        for (int i = 1; i <= 5; i++) send_be(32'hB0D0_0000 + 32'(i), i == 5);
      end
      begin
        repeat (10) @(negedge clk);
        check("bp_in_be_ready", in_be_ready, 0);
        check("bp_be_valid", be_out_valid, 5'b00010);
        @(posedge clk);
        #1 be_out_ready = '1;
      end
    join
    cycles(6);

    // Illegal route then a legal packet
    drop_pending++;
    send_be(32'h0000_0007, 1'b0);
    send_be(32'h1111_2222, 1'b1);
    expect_be(3'd3, 32'h0000_0002, 1'b1);
    send_be(32'h0000_0013, 1'b1);
    cycles(5);

    // TDM and BE collide: TDM wins, BE not pushed
    in_tdm_valid = 1'b1; in_be_valid = 1'b1; in_flit = 32'h1234_5670; in_last = 1'b1;
    tdm_q.push_back({1'b1, 32'h1234_5670});
    cycles(1);
    in_tdm_valid = 1'b0; in_be_valid = 1'b0; in_last = 1'b0;
    cycles(5);

    // Reset mid-packet while in FWD
    expect_be(3'd4, 32'h0000_0000, 1'b0);
    send_be(32'h0000_0004, 1'b0);
    cycles(2);
    be_out_ready = 5'b01111;
    send_be(32'h5555_0001, 1'b0);
    cycles(2);
    @(negedge clk);
    check("fwd_hold_valid", be_out_valid, 5'b10000);
    @(posedge clk);
    #1 rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    be_out_ready = '1;
    @(negedge clk);
    check("post_rst_be_valid", be_out_valid, 0);
    check("post_rst_ready", in_be_ready, 1);
    cycles(1);
    expect_be(3'd0, 32'h0000_0002, 1'b1);
    send_be(32'h0000_0010, 1'b1);

    // Drain
    w = 0;
    while ((be_q.size() != 0 || tdm_q.size() != 0 || drop_pending != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    cycles(3);
    check("be_q_empty", be_q.size(), 0);
    check("tdm_q_empty", tdm_q.size(), 0);
    check("drop_pending", drop_pending, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
